note_window_scroller: RTL
=========================

# note_window_scroller

Parametrised note-highway scroller for the LED-matrix rhythm game. It fetches 2-bit note codes for the selected song from an external synchronous note ROM and presents a WIN-slot visible window as per-slot R/G/B lane bits. A pixel offset is advanced every tick, and the window shifts one note every PIX steps. It feeds the matrix driver and adds green notes, pause, speed modes, looping and a start/busy/finish handshake.

## Interface
- WIN, 10: visible note slots (≥2).
- PIX, 7: pixel steps per note (2..15).
- TICK, 1000: clk cycles per pixel step at speed ×1 (≥8).
- AW, 8: note ROM address width.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- song_base  in  AW  ROM address of note 0; latched on accepted start.
- song_len  in  AW  number of notes; latched on accepted start.
- pause  in  1  freezes tick counter in RUN.
- speed  in  2  00 ×1, 01 ×2, 10 ×4, 11 treated as ×1; sampled live.
- loop  in  1  sampled at end of song; 1 restarts the same song.
- rom_addr  out  AW  note ROM read address.
- rom_data  in  2  note code, valid one cycle after rom_addr.
- note_R / note_G / note_B  out  WIN  lane colour bits; bit 0 is the slot at the hit line.
- offset  out  4  pixel offset 0..PIX-1.
- step  out  1  one-cycle pulse on each pixel step.
- busy  out  1  high in LOAD, RUN and FINISH.
- finish  out  1  one-cycle pulse at song end.

## Operation
- Note codes: 0 empty (RGB 000), 1 red (100), 2 blue (001), 3 green (010). Slot k holds note idx+k. Notes with index ≥ len read as code 0 and are not fetched from ROM.
- rom_addr = base + note index, modulo 2^AW. It holds its last value when no read is issued.
- States:
  - IDLE: window, offset and idx are 0. Accepted start goes to LOAD, or to FINISH if song_len=0.
  - LOAD: issues reads for notes 0..WIN-1 on consecutive cycles and captures each into its slot one cycle later. After the last capture, goes to RUN with offset 0 and idx 0. pause and speed are ignored.
  - RUN: tick_cnt increments each cycle unless pause=1. When tick_cnt ≥ (TICK>>s)-1, with s = 0/1/2 per speed, a step occurs: tick_cnt clears and step pulses.
    - If offset < PIX-1, the step increments offset.
    - Otherwise it is a shift: offset→0, slot k←slot k+1, slot WIN-1←prefetch register, idx←idx+1.
    - The cycle after each shift (and at RUN entry), a read is issued for note idx+WIN. Data is captured into the prefetch register one cycle later, or 0 if that note index ≥ len.
    - When a shift makes idx == len, go to FINISH.
  - FINISH: finish=1 for one cycle. Then, if loop=1, go to LOAD with the same base and len; otherwise go to IDLE and clear the window.
- start outside IDLE is ignored. song_base and song_len changes after acceptance have no effect.
- A speed change mid-run applies on the next compare. If tick_cnt is already ≥ the new threshold, the step fires on that cycle.
- pause freezes tick_cnt, offset and the window. It never drops or delays a ROM capture already in flight.

## Timing
- Reset values: all outputs 0, including rom_addr, offset, step, busy and finish. State goes to IDLE and tick_cnt, idx and the prefetch register clear.
- rst mid-operation aborts immediately with no finish pulse.
- With start accepted at cycle 0:
  - busy is 1 from cycle 1.
  - LOAD rom_addr = base+k at cycle 1+k.
  - Slot k is valid at cycle 2+k.
  - RUN is entered at cycle WIN+2.
  - The first step occurs TICK>>s cycles after RUN entry, unpaused.
- Pixel steps are TICK>>s cycles apart. A shift occurs every PIX steps.
- The prefetch completes two cycles after a shift, always before the next step (TICK>>2 ≥ 2).
- Song duration unpaused from RUN entry: len·PIX·(TICK>>s) cycles, then finish in the next cycle.
- With song_len=0, start at cycle 0 gives finish at cycle 1 and IDLE at cycle 2.

## Test plan
- WIN=10, PIX=7, TICK=8, len=12, ROM = 1,2,3,0,… repeating:
  - after load, note_R[0]=1, note_B[1]=1 and note_G[2]=1;
  - the first shift occurs 56 cycles after RUN entry;
  - finish pulses exactly once at 12·56 cycles, then busy=0.
- len=3 (< WIN): slots 3..9 stay 000 for the whole song. rom_addr never exceeds base+2.
- pause=1 for 20 cycles mid-step: offset, window and tick_cnt hold. The step is delayed by exactly 20 cycles.
- speed=10, TICK=8: steps arrive every 2 cycles. Switching to 00 mid-run restores 8-cycle spacing from the next step.
- loop=1, len=2: finish pulses, then LOAD restarts at rom_addr=base, busy stays 1 throughout, and a second finish follows after the same duration.
- song_len=0 start → finish at cycle 1. Then rst mid-RUN → all outputs 0 immediately, no finish pulse, and start after reset is accepted normally.

Source files
------------

// File: rtl/note_window_scroller.sv
// note_window_scroller: fetches 2-bit note codes from a synchronous note ROM
// and scrolls a WIN-slot window of R/G/B lane bits toward the hit line.
// The pixel offset advances every (TICK>>speed) cycles. The window shifts by
// one note every PIX pixel steps.
module note_window_scroller #(
  parameter int WIN  = 10,
  parameter int PIX  = 7,
  parameter int TICK = 1000,
  parameter int AW   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [AW-1:0]  song_base,
  input  logic [AW-1:0]  song_len,
  input  logic           pause,
  input  logic [1:0]     speed,
  input  logic           loop,
  output logic [AW-1:0]  rom_addr,
  input  logic [1:0]     rom_data,
  output logic [WIN-1:0] note_R,
  output logic [WIN-1:0] note_G,
  output logic [WIN-1:0] note_B,
  output logic [3:0]     offset,
  output logic           step,
  output logic           busy,
  output logic           finish
);

  localparam int TW = $clog2(TICK);       // holds TICK-1
  localparam int LW = $clog2(WIN + 1);    // holds WIN (prefetch target tag)
  localparam int NW = AW + LW + 1;        // note index wide enough for idx+WIN

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FINISH} state_t;

  state_t          state_q;
  logic [AW-1:0]   base_q, len_q, idx_q, rom_addr_q;
  logic [TW-1:0]   tick_q;
  logic [3:0]      offset_q;
  logic            step_q;
  logic [1:0]      slot_q [WIN];
  logic [1:0]      pf_q;
  logic [LW-1:0]   ld_cnt_q;
  // Two-stage read tracker: iss = address on rom_addr this cycle,
  // cap = ROM data valid this cycle and captured at the coming edge.
  logic            iss_q, cap_q, iss_zero_q, cap_zero_q;
  logic [LW-1:0]   iss_tgt_q, cap_tgt_q;

  logic [TW-1:0]   thr;
  logic [NW-1:0]   fetch_idx;
  logic            fetch_hit, ld_hit;
  logic [1:0]      cap_val;

  // Step threshold from the live speed setting; 11 behaves as x1.
  always_comb begin
    // NOTE: every combinational output gets a default so no latch is inferred.
    thr = TW'(TICK - 1);
    unique case (speed)
      2'b01:   thr = TW'((TICK >> 1) - 1);
      2'b10:   thr = TW'((TICK >> 2) - 1);
      default: thr = TW'(TICK - 1);
    endcase
  end

  // Fetch index/bounds helpers and the value a landing capture writes.
  always_comb begin
    fetch_idx = (state_q == S_RUN) ? NW'(idx_q) + NW'(WIN + 1) : NW'(WIN);
    fetch_hit = fetch_idx < NW'(len_q);
    ld_hit    = NW'(ld_cnt_q) < NW'(len_q);
    cap_val   = cap_zero_q ? 2'b00 : rom_data;
  end

  // Control FSM plus window/prefetch datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the window registers drive outputs directly, so unlike a plain
      // storage array they are reset.
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      rom_addr_q <= '0;
      tick_q     <= '0;
      offset_q   <= '0;
      step_q     <= 1'b0;
      pf_q       <= '0;
      ld_cnt_q   <= '0;
      iss_q      <= 1'b0;
      cap_q      <= 1'b0;
      iss_zero_q <= 1'b0;
      cap_zero_q <= 1'b0;
      iss_tgt_q  <= '0;
      cap_tgt_q  <= '0;
      for (int k = 0; k < WIN; k++) slot_q[k] <= '0;
    end else begin
      step_q     <= 1'b0;
      iss_q      <= 1'b0;
      cap_q      <= iss_q;
      cap_tgt_q  <= iss_tgt_q;
      cap_zero_q <= iss_zero_q;

      // Reads already in flight always land, whatever the state or pause.
      if (cap_q) begin
        if (cap_tgt_q == LW'(WIN)) pf_q <= cap_val;
        for (int k = 0; k < WIN; k++)
          if (cap_tgt_q == LW'(k)) slot_q[k] <= cap_val;
      end

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q <= song_base;
            len_q  <= song_len;
            if (song_len == '0) begin
              state_q <= S_FINISH;
            end else begin
              state_q    <= S_LOAD;
              rom_addr_q <= song_base;
              iss_q      <= 1'b1;
              iss_tgt_q  <= '0;
              iss_zero_q <= 1'b0;
              ld_cnt_q   <= LW'(1);
            end
          end
        end

        S_LOAD: begin
          if (ld_cnt_q < LW'(WIN)) begin
            // Notes past the end of the song are not fetched; they land as 0.
            if (ld_hit) rom_addr_q <= base_q + AW'(ld_cnt_q);
            iss_q      <= 1'b1;
            iss_tgt_q  <= ld_cnt_q;
            iss_zero_q <= !ld_hit;
            ld_cnt_q   <= ld_cnt_q + LW'(1);
          end
          if (cap_q && cap_tgt_q == LW'(WIN - 1)) begin
            state_q  <= S_RUN;
            offset_q <= '0;
            idx_q    <= '0;
            tick_q   <= '0;
            if (fetch_hit) rom_addr_q <= base_q + fetch_idx[AW-1:0];
            iss_q      <= 1'b1;
            iss_tgt_q  <= LW'(WIN);
            iss_zero_q <= !fetch_hit;
          end
        end

        S_RUN: begin
          if (idx_q == len_q) begin
            state_q <= S_FINISH;
          end else if (!pause) begin
            if (tick_q >= thr) begin
              tick_q <= '0;
              step_q <= 1'b1;
              if (offset_q < 4'(PIX - 1)) begin
                offset_q <= offset_q + 4'd1;
              end else begin
                offset_q <= '0;
                for (int k = 0; k < WIN - 1; k++) slot_q[k] <= slot_q[k+1];
                slot_q[WIN-1] <= pf_q;
                idx_q <= idx_q + AW'(1);
                if (fetch_hit) rom_addr_q <= base_q + fetch_idx[AW-1:0];
                iss_q      <= 1'b1;
                iss_tgt_q  <= LW'(WIN);
                iss_zero_q <= !fetch_hit;
              end
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end

        S_FINISH: begin
          // An empty song never loops, so finish stays a single pulse.
          if (loop && len_q != '0) begin
            state_q    <= S_LOAD;
            rom_addr_q <= base_q;
            iss_q      <= 1'b1;
            iss_tgt_q  <= '0;
            iss_zero_q <= 1'b0;
            ld_cnt_q   <= LW'(1);
            offset_q   <= '0;
            idx_q      <= '0;
            tick_q     <= '0;
          end else begin
            state_q  <= S_IDLE;
            offset_q <= '0;
            idx_q    <= '0;
            tick_q   <= '0;
            for (int k = 0; k < WIN; k++) slot_q[k] <= '0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Decode stored note codes into lane colour bits.
  always_comb begin
    for (int k = 0; k < WIN; k++) begin
      note_R[k] = (slot_q[k] == 2'd1);
      note_B[k] = (slot_q[k] == 2'd2);
      note_G[k] = (slot_q[k] == 2'd3);
    end
  end

  assign rom_addr = rom_addr_q;
  assign offset   = offset_q;
  assign step     = step_q;
  assign busy     = (state_q != S_IDLE);
  assign finish   = (state_q == S_FINISH);

endmodule
